cache_nwsa_wb: RTL

CACHE_NWSA_WB -- requirements
Module: cache_nwsa_wb

---
 rtl/cache_nwsa_wb.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_nwsa_wb.sv
// N-way set-associative write-back, write-allocate byte cache with round-robin replacement and full flush.
// Hit acks two cycles after acceptance; line transfers stall while mem_ready/mem_rvalid are low.
module cache_nwsa_wb #(
  parameter int AWIDTH    = 9,
  parameter int DWIDTH    = 8,
  parameter int BLOCKSIZE = 4,
  parameter int NUMSETS   = 8,
  parameter int NUMWAYS   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  input  logic              flush,
  output logic              flush_done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_ready
);
  localparam int IDXW   = $clog2(NUMSETS);
  localparam int OFFW   = $clog2(BLOCKSIZE);
  localparam int TAGW   = AWIDTH - IDXW - OFFW;
  localparam int WW     = $clog2(NUMWAYS);
  localparam int KW     = OFFW + 1;
  localparam int SCANW  = IDXW + WW + 1;
  localparam int NLINES = NUMSETS * NUMWAYS;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_FLUSH} state_t;

  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [WW-1:0]     victim_q, victim_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SCANW-1:0]  scan_q, scan_d;
  logic              flushing_q, flushing_d, ack_q, ack_d, done_q, done_d;

  logic [NUMSETS-1:0][NUMWAYS-1:0] valid_q, dirty_q;
  logic [NUMSETS-1:0][WW-1:0]      rr_q;
  logic [DWIDTH-1:0] data_q [NUMSETS][NUMWAYS][BLOCKSIZE];
  logic [TAGW-1:0]   tag_q  [NUMSETS][NUMWAYS];

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx, idx;
  logic [OFFW-1:0] req_off;
  logic [WW-1:0]   scan_way, hit_way, victim;
  logic            hit, last_byte, scan_end, line_dirty, refill_done;

  assign {req_tag, req_idx, req_off} = addr_q;
  // During a flush the active set comes from the scan counter, otherwise from the request.
  assign idx         = flushing_q ? scan_q[WW +: IDXW] : req_idx;
  assign scan_way    = scan_q[WW-1:0];
  assign last_byte   = (k_q == KW'(BLOCKSIZE - 1));
  assign scan_end    = (scan_q == SCANW'(NLINES));
  assign line_dirty  = valid_q[idx][scan_way] && dirty_q[idx][scan_way];
  assign refill_done = (state_q == S_REFILL) && mem_rvalid && last_byte;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = rr_q[idx];
    for (int w = NUMWAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) victim = WW'(w);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (flush && !done_q)        state_d = S_FLUSH;
                else if (cpu_req && !ack_q)  state_d = S_LOOKUP;
      S_LOOKUP: if (hit)                     state_d = S_IDLE;
                else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = S_WB;
                else                         state_d = S_REFILL;
      S_WB:     if (mem_ready && last_byte)  state_d = flushing_q ? S_FLUSH : S_REFILL;
      S_REFILL: if (mem_rvalid && last_byte) state_d = S_LOOKUP;
      S_FLUSH:  if (scan_end)                state_d = S_IDLE;
                else if (line_dirty)         state_d = S_WB;
      default:                               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_busy  = (state_q != S_IDLE);
    mem_wr    = (state_q == S_WB);
    mem_rd    = (state_q == S_REFILL);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_WB) begin
      mem_addr  = {tag_q[idx][victim_q], idx, {OFFW{1'b0}}};
      mem_wdata = data_q[idx][victim_q][k_q[OFFW-1:0]];
    end else if (state_q == S_REFILL) begin
      mem_addr  = {req_tag, idx, {OFFW{1'b0}}};
    end
  end

  always_comb begin
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    victim_d   = victim_q;
    k_d        = k_q;
    scan_d     = scan_q;
    flushing_d = flushing_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE:
        if (flush && !done_q) begin
          flushing_d = 1'b1;
          scan_d     = '0;
        end else if (cpu_req && !ack_q) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
        end
      S_LOOKUP:
        if (hit) begin
          ack_d = 1'b1;
          if (!we_q) rdata_d = data_q[idx][hit_way][req_off];
        end else begin
          victim_d = victim;
          k_d      = '0;
        end
      S_WB:
        if (mem_ready) begin
          k_d = last_byte ? '0 : k_q + 1'b1;
          if (last_byte && flushing_q) scan_d = scan_q + 1'b1;
        end
      S_REFILL:
        if (mem_rvalid) k_d = last_byte ? '0 : k_q + 1'b1;
      S_FLUSH:
        if (scan_end) begin
          flushing_d = 1'b0;
          done_d     = 1'b1;
        end else if (line_dirty) begin
          victim_d = scan_way;
          k_d      = '0;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      victim_q   <= '0;
      k_q        <= '0;
      scan_q     <= '0;
      flushing_q <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      rr_q       <= '0;
    end else begin
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      victim_q   <= victim_d;
      k_q        <= k_d;
      scan_q     <= scan_d;
      flushing_q <= flushing_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      if (state_q == S_LOOKUP && hit && we_q) dirty_q[idx][hit_way] <= 1'b1;
      if (refill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        rr_q[idx]              <= victim_q + 1'b1;
      end
      if (state_q == S_FLUSH && scan_end) begin
        valid_q <= '0;
        dirty_q <= '0;
      end
    end
  end

  // Line storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clock) begin
    if (state_q == S_REFILL && mem_rvalid) data_q[idx][victim_q][k_q[OFFW-1:0]] <= mem_rdata;
    if (refill_done) tag_q[idx][victim_q] <= req_tag;
    if (state_q == S_LOOKUP && hit && we_q) data_q[idx][hit_way][req_off] <= wdata_q;
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ack    = ack_q;
  assign flush_done = done_q;
endmodule
